// File: rtl/nrzi_unstuff_rx_if.sv
// Line-side samples and enable into the receiver, decoded bit stream and status pulses out.
// master drives the line and enable; slave is the receiver.
interface nrzi_unstuff_rx_if;
    logic dp_in;
    logic dm_in;
    logic en_L;
    logic dec_bit;
    logic bit_valid;
    logic pause;
    logic eop_done;
    logic stuff_err;
    logic se0_err;

    modport master (
        output dp_in, dm_in, en_L,
        input  dec_bit, bit_valid, pause, eop_done, stuff_err, se0_err
    );

    modport slave (
        input  dp_in, dm_in, en_L,
        output dec_bit, bit_valid, pause, eop_done, stuff_err, se0_err
    );
endinterface

// File: rtl/nrzi_unstuff_rx.sv
// NRZI decoder with bit unstuffing and EOP / line-error detection.
// Latency: one cycle, all outputs registered. No backpressure: one line sample per cycle; pause marks dropped stuff bits.
module nrzi_unstuff_rx #(
    parameter int STUFF_LEN = 6
) (
    input  logic              clk,
    input  logic              rst_L,
    nrzi_unstuff_rx_if.slave  rx
);

    localparam int CW = $clog2(STUFF_LEN + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STUFF_LEN);

    typedef enum logic [2:0] {IDLE, RUN, EOP1, EOP2, ERR} state_t;

    state_t         state, state_nxt;
    logic           prev_level, prev_nxt;     // 1 = J, 0 = K
    logic [CW-1:0]  ones_cnt, cnt_nxt;

    logic dec_q, valid_q, pause_q, eop_q, serr_q, se0err_q;
    logic dec_nxt, valid_nxt, pause_nxt, eop_nxt, serr_nxt, se0err_nxt;

    logic           is_j, is_se0, is_se1;
    logic           ref_level, bit_one;
    logic [CW-1:0]  ref_cnt;

    assign is_j   =  rx.dp_in & ~rx.dm_in;
    assign is_se0 = ~rx.dp_in & ~rx.dm_in;
    assign is_se1 =  rx.dp_in &  rx.dm_in;

    // Leaving IDLE, the sample is decoded against a fresh J reference with an empty ones count.
    assign ref_level = (state == IDLE) ? 1'b1 : prev_level;
    assign ref_cnt   = (state == IDLE) ? '0   : ones_cnt;
    assign bit_one   = (is_j == ref_level);

    always_comb begin
        state_nxt  = state;
        prev_nxt   = prev_level;
        cnt_nxt    = ones_cnt;
        dec_nxt    = 1'b0;
        valid_nxt  = 1'b0;
        pause_nxt  = 1'b0;
        eop_nxt    = 1'b0;
        serr_nxt   = 1'b0;
        se0err_nxt = 1'b0;

        if (rx.en_L) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, RUN: begin
                    state_nxt = RUN;
                    prev_nxt  = ref_level;
                    cnt_nxt   = ref_cnt;
                    if (is_se1) begin
                        se0err_nxt = 1'b1;
                        state_nxt  = ERR;
                    end else if (is_se0) begin
                        state_nxt = EOP1;
                    end else begin
                        prev_nxt = is_j;
                        if (ref_cnt == CNT_MAX) begin
                            if (bit_one) begin
                                serr_nxt  = 1'b1;
                                state_nxt = ERR;
                            end else begin
                                pause_nxt = 1'b1;
                                cnt_nxt   = '0;
                            end
                        end else begin
                            valid_nxt = 1'b1;
                            dec_nxt   = bit_one;
                            cnt_nxt   = bit_one ? ref_cnt + 1'b1 : '0;
                        end
                    end
                end
                EOP1: begin
                    if (is_se0) begin
                        state_nxt = EOP2;
                    end else begin
                        se0err_nxt = 1'b1;
                        state_nxt  = ERR;
                    end
                end
                EOP2: begin
                    if (is_j) begin
                        eop_nxt   = 1'b1;
                        prev_nxt  = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        se0err_nxt = 1'b1;
                        state_nxt  = ERR;
                    end
                end
                ERR: begin
                    state_nxt = ERR;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state      <= IDLE;
            prev_level <= 1'b1;
            ones_cnt   <= '0;
            dec_q      <= 1'b0;
            valid_q    <= 1'b0;
            pause_q    <= 1'b0;
            eop_q      <= 1'b0;
            serr_q     <= 1'b0;
            se0err_q   <= 1'b0;
        end else begin
            state      <= state_nxt;
            prev_level <= prev_nxt;
            ones_cnt   <= cnt_nxt;
            dec_q      <= dec_nxt;
            valid_q    <= valid_nxt;
            pause_q    <= pause_nxt;
            eop_q      <= eop_nxt;
            serr_q     <= serr_nxt;
            se0err_q   <= se0err_nxt;
        end
    end

    assign rx.dec_bit   = dec_q;
    assign rx.bit_valid = valid_q;
    assign rx.pause     = pause_q;
    assign rx.eop_done  = eop_q;
    assign rx.stuff_err = serr_q;
    assign rx.se0_err   = se0err_q;

endmodule

// File: tb/tb_nrzi_unstuff_rx.sv
// Bench for nrzi_unstuff_rx: directed line scenarios plus random packets built by an
// independent stuff-and-NRZI encoder whose per-symbol expectations come straight from the payload.
module tb_nrzi_unstuff_rx;

    localparam int SL = 6;

    typedef enum {SYM_J, SYM_K, SYM_SE0, SYM_SE1} sym_t;

    // {dec_bit, bit_valid, pause, eop_done, stuff_err, se0_err}
    localparam logic [5:0] E_ZERO = 6'b000000;
    localparam logic [5:0] E_D0   = 6'b010000;
    localparam logic [5:0] E_D1   = 6'b110000;
    localparam logic [5:0] E_PAUS = 6'b001000;
    localparam logic [5:0] E_EOP  = 6'b000100;
    localparam logic [5:0] E_SERR = 6'b000010;
    localparam logic [5:0] E_LERR = 6'b000001;

    logic clk = 1'b0;
    logic rst_L = 1'b0;
    int   tests = 0;
    int   fails = 0;

    sym_t       sym_q[$];
    logic [5:0] exp_q[$];

    nrzi_unstuff_rx_if bus ();

    nrzi_unstuff_rx #(.STUFF_LEN(SL)) dut (
        .clk   (clk),
        .rst_L (rst_L),
        .rx    (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {bus.dec_bit, bus.bit_valid, bus.pause, bus.eop_done, bus.stuff_err, bus.se0_err};
    endfunction

    task automatic drive(input sym_t s, input logic en);
        case (s)
            SYM_J:   begin bus.dp_in = 1'b1; bus.dm_in = 1'b0; end
            SYM_K:   begin bus.dp_in = 1'b0; bus.dm_in = 1'b1; end
            SYM_SE0: begin bus.dp_in = 1'b0; bus.dm_in = 1'b0; end
            default: begin bus.dp_in = 1'b1; bus.dm_in = 1'b1; end
        endcase
        bus.en_L = en;
    endtask

    // Present one sample, let the DUT take it, and check the cycle that reflects it.
    task automatic step(input string name, input sym_t s, input logic en, input logic [5:0] exp);
        logic [5:0] got;
        drive(s, en);
        @(posedge clk);
        #1;
        got = outs();
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s #%0d: got %b expected %b (dec,vld,pause,eop,stuff_err,se0_err)",
                     name, tests, got, exp);
        end
    endtask

    // Payload -> stuffed NRZI symbols plus EOP, starting from a J reference.
    task automatic build_packet(input int nbits, input int one_bias);
        logic level;
        int   ones;
        logic b;
        level = 1'b1;
        ones  = 0;
        for (int i = 0; i < nbits; i++) begin
            b = ($urandom_range(0, 99) < one_bias);
            if (!b) level = ~level;
            sym_q.push_back(level ? SYM_J : SYM_K);
            exp_q.push_back(b ? E_D1 : E_D0);
            ones = b ? ones + 1 : 0;
            if (ones == SL) begin
                level = ~level;
                sym_q.push_back(level ? SYM_J : SYM_K);
                exp_q.push_back(E_PAUS);
                ones = 0;
            end
        end
        sym_q.push_back(SYM_SE0); exp_q.push_back(E_ZERO);
        sym_q.push_back(SYM_SE0); exp_q.push_back(E_ZERO);
        sym_q.push_back(SYM_J);   exp_q.push_back(E_EOP);
    endtask

    task automatic play(input string name);
        while (sym_q.size() > 0) begin
            step(name, sym_q.pop_front(), 1'b0, exp_q.pop_front());
        end
    endtask

    task automatic test_reset();
        logic [5:0] got;
        drive(SYM_K, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        got = outs();
        tests++;
        if (got !== E_ZERO) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected %b", got, E_ZERO);
        end
        drive(SYM_J, 1'b1);
        #2 rst_L = 1'b1;
        @(posedge clk);
        #1;
        step("reset_idle", SYM_K, 1'b1, E_ZERO);
    endtask

    task automatic test_sync();
        step("sync", SYM_K, 1'b0, E_D0);
        step("sync", SYM_J, 1'b0, E_D0);
        step("sync", SYM_K, 1'b0, E_D0);
        step("sync", SYM_J, 1'b0, E_D0);
        step("sync", SYM_K, 1'b0, E_D0);
        step("sync", SYM_J, 1'b0, E_D0);
        step("sync", SYM_K, 1'b0, E_D0);
        step("sync", SYM_K, 1'b0, E_D1);
        step("sync_exit", SYM_K, 1'b1, E_ZERO);
    endtask

    task automatic test_stuffing();
        step("stuff", SYM_K, 1'b0, E_D0);
        step("stuff", SYM_J, 1'b0, E_D0);
        repeat (SL) step("stuff_ones", SYM_J, 1'b0, E_D1);
        step("stuff_pause", SYM_K, 1'b0, E_PAUS);
        step("stuff_next", SYM_K, 1'b0, E_D1);
        step("stuff_next", SYM_J, 1'b0, E_D0);
        step("stuff_exit", SYM_J, 1'b1, E_ZERO);
    endtask

    task automatic test_stuff_violation();
        step("viol", SYM_K, 1'b0, E_D0);
        step("viol", SYM_J, 1'b0, E_D0);
        repeat (SL) step("viol_ones", SYM_J, 1'b0, E_D1);
        step("viol_err", SYM_J, 1'b0, E_SERR);
        step("viol_hold", SYM_K, 1'b0, E_ZERO);
        step("viol_hold", SYM_SE0, 1'b0, E_ZERO);
        step("viol_hold", SYM_J, 1'b0, E_ZERO);
        step("viol_exit", SYM_J, 1'b1, E_ZERO);
        step("viol_idle", SYM_K, 1'b1, E_ZERO);
    endtask

    task automatic test_eop();
        step("eop", SYM_K, 1'b0, E_D0);
        step("eop", SYM_J, 1'b0, E_D0);
        step("eop", SYM_J, 1'b0, E_D1);
        step("eop_se0", SYM_SE0, 1'b0, E_ZERO);
        step("eop_se0", SYM_SE0, 1'b0, E_ZERO);
        step("eop_done", SYM_J, 1'b0, E_EOP);
        step("eop_after", SYM_J, 1'b1, E_ZERO);
        // SE0 while the ones count sits at the limit is an EOP, not a stuff error
        step("eop_lim", SYM_K, 1'b0, E_D0);
        step("eop_lim", SYM_J, 1'b0, E_D0);
        repeat (SL) step("eop_lim_ones", SYM_J, 1'b0, E_D1);
        step("eop_lim_se0", SYM_SE0, 1'b0, E_ZERO);
        step("eop_lim_se0", SYM_SE0, 1'b0, E_ZERO);
        step("eop_lim_done", SYM_J, 1'b0, E_EOP);
        step("eop_lim_exit", SYM_K, 1'b1, E_ZERO);
    endtask

    task automatic test_bad_eop();
        step("bad_se0k", SYM_K, 1'b0, E_D0);
        step("bad_se0k", SYM_SE0, 1'b0, E_ZERO);
        step("bad_se0k_err", SYM_K, 1'b0, E_LERR);
        step("bad_se0k_exit", SYM_K, 1'b1, E_ZERO);
        step("bad_3se0", SYM_K, 1'b0, E_D0);
        step("bad_3se0", SYM_SE0, 1'b0, E_ZERO);
        step("bad_3se0", SYM_SE0, 1'b0, E_ZERO);
        step("bad_3se0_err", SYM_SE0, 1'b0, E_LERR);
        step("bad_3se0_exit", SYM_K, 1'b1, E_ZERO);
        step("bad_se1", SYM_K, 1'b0, E_D0);
        step("bad_se1_err", SYM_SE1, 1'b0, E_LERR);
        step("bad_se1_hold", SYM_J, 1'b0, E_ZERO);
        step("bad_se1_exit", SYM_J, 1'b1, E_ZERO);
        step("bad_eop2k", SYM_K, 1'b0, E_D0);
        step("bad_eop2k", SYM_SE0, 1'b0, E_ZERO);
        step("bad_eop2k", SYM_SE0, 1'b0, E_ZERO);
        step("bad_eop2k_err", SYM_K, 1'b0, E_LERR);
        step("bad_eop2k_exit", SYM_K, 1'b1, E_ZERO);
    endtask

    task automatic test_abort_reset();
        logic [5:0] got;
        step("abort", SYM_K, 1'b0, E_D0);
        step("abort", SYM_J, 1'b0, E_D0);
        step("abort", SYM_J, 1'b0, E_D1);
        step("abort_en", SYM_SE0, 1'b1, E_ZERO);
        step("abort_restart", SYM_K, 1'b0, E_D0);
        step("abort_restart", SYM_K, 1'b0, E_D1);
        #2 rst_L = 1'b0;
        #1;
        got = outs();
        tests++;
        if (got !== E_ZERO) begin
            fails++;
            $display("FAIL async_reset: got %b expected %b", got, E_ZERO);
        end
        drive(SYM_K, 1'b1);
        #3 rst_L = 1'b1;
        @(posedge clk);
        #1;
        step("post_reset_idle", SYM_K, 1'b1, E_ZERO);
        test_sync();
    endtask

    task automatic test_random_packets();
        int gap;
        for (int p = 0; p < 25; p++) begin
            gap = $urandom_range(1, 3);
            for (int g = 0; g < gap; g++) begin
                step("rand_gap", sym_t'($urandom_range(0, 3)), 1'b1, E_ZERO);
            end
            build_packet($urandom_range(1, 48), 75);
            play("rand_pkt");
        end
        step("rand_exit", SYM_J, 1'b1, E_ZERO);
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 10; p++) begin
            build_packet($urandom_range(1, 24), 85);
        end
        play("b2b_pkt");
        step("b2b_exit", SYM_K, 1'b1, E_ZERO);
    endtask

    initial begin
        bus.dp_in = 1'b1;
        bus.dm_in = 1'b0;
        bus.en_L  = 1'b1;
        test_reset();
        test_sync();
        test_stuffing();
        test_stuff_violation();
        test_eop();
        test_bad_eop();
        test_abort_reset();
        test_random_packets();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
